// File: rtl/synth_pkg.sv
// Shared types, constants and the note-to-half-period table for the
// multi-voice square-wave sequencer.
package synth_pkg;

   localparam int unsigned NOTE_REST = 0;
   localparam int unsigned NOTE_MAX  = 63;   // highest code with a table entry
   localparam int unsigned HP_W      = 18;   // holds the longest half period (A2)

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      PLAY  = 2'd2
   } state_e;

   // Half period in 50 MHz cycles for an equal-tempered scale, code 1 = A2 (110 Hz).
   // One octave of rounded base values is stored and halved per octave up.
   // Returns 0 for a rest or a code with no table entry (silent voice).
   function automatic int unsigned HALF_PERIOD(input int unsigned note);
      int unsigned semi;
      int unsigned octave;
      int unsigned base;
      if (note == NOTE_REST || note > NOTE_MAX) begin
         return 0;
      end
      octave = (note - 1) / 12;
      semi   = (note - 1) % 12;
      case (semi)
         0:       base = 227273;
         1:       base = 214517;
         2:       base = 202477;
         3:       base = 191113;
         4:       base = 180386;
         5:       base = 170262;
         6:       base = 160706;
         7:       base = 151686;
         8:       base = 143173;
         9:       base = 135137;
         10:      base = 127553;
         default: base = 120394;
      endcase
      return base >> octave;
   endfunction

endpackage

// File: rtl/multi_voice_synth_voice.sv
// One square-wave voice: holds its note, times each half period with a
// down-counter and produces a signed +/-VOICE_AMP (or 0) contribution.
module square_voice
   import synth_pkg::*;
#(
   parameter int                 NOTE_W    = 6,
   parameter int                 AMP_W     = 32,
   parameter logic [AMP_W-1:0]   VOICE_AMP = 32'h0800_0000
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  load,
   input  logic [NOTE_W-1:0]     note,
   input  logic                  mute,
   output logic [AMP_W-1:0]      contrib
);

   logic [NOTE_W-1:0] note_q, note_d;
   logic [HP_W-1:0]   cnt_q, cnt_d;
   logic              phase_q, phase_d;   // 1 = positive half
   logic              audible;

   // Reload value for the half-period down-counter; silent codes reload 0.
   function automatic logic [HP_W-1:0] reload_of(input logic [NOTE_W-1:0] n);
      int unsigned hp;
      hp = HALF_PERIOD(32'(n));
      if (hp == 0) begin
         return '0;
      end
      return HP_W'(hp - 1);
   endfunction

   // Next-state: a load restarts the waveform at the top of the + half.
   always_comb begin
      note_d  = note_q;
      cnt_d   = cnt_q;
      phase_d = phase_q;
      if (load) begin
         note_d  = note;
         cnt_d   = reload_of(note);
         phase_d = 1'b1;
      end else if (cnt_q == '0) begin
         cnt_d   = reload_of(note_q);
         phase_d = ~phase_q;
      end else begin
         cnt_d   = cnt_q - 1'b1;
      end
   end

   // Voice state registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         note_q  <= '0;
         cnt_q   <= '0;
         phase_q <= 1'b1;
      end else begin
         note_q  <= note_d;
         cnt_q   <= cnt_d;
         phase_q <= phase_d;
      end
   end

   // Output level; rests and muted voices keep counting but stay silent.
   always_comb begin
      audible = (HALF_PERIOD(32'(note_q)) != 0) && !mute;
      if (!audible) begin
         contrib = '0;
      end else if (phase_q) begin
         contrib = VOICE_AMP;
      end else begin
         contrib = '0 - VOICE_AMP;
      end
   end

endmodule

// File: rtl/multi_voice_synth.sv
// Step sequencer driving NUM_VOICES square voices into one summed sample
// for the Audio_Controller write handshake.
module multi_voice_synth
   import synth_pkg::*;
#(
   parameter int               NUM_VOICES = 3,
   parameter int               NOTE_W     = 6,
   parameter int               SEQ_DEPTH  = 64,
   parameter int               TICK_DIV   = 12500000,
   parameter int               AMP_W      = 32,
   parameter logic [AMP_W-1:0] VOICE_AMP  = 32'h0800_0000,
   localparam int              LEN_W      = $clog2(SEQ_DEPTH + 1),
   localparam int              ADDR_W     = $clog2(SEQ_DEPTH),
   localparam int              TICK_W     = $clog2(TICK_DIV + 1)
) (
   input  logic                         CLOCK_50,
   input  logic                         reset,
   input  logic                         start,
   input  logic                         stop,
   input  logic                         loop_en,
   input  logic [LEN_W-1:0]             seq_len,
   input  logic [NUM_VOICES-1:0]        mute_mask,
   input  logic                         note_wr_en,
   input  logic [ADDR_W-1:0]            note_wr_addr,
   input  logic [NUM_VOICES*NOTE_W-1:0] note_wr_data,
   input  logic                         audio_out_allowed,
   output logic [AMP_W-1:0]             sample_out,
   output logic                         write_audio_out,
   output logic                         playing,
   output logic [ADDR_W-1:0]            step_idx,
   output logic                         done
);

   // state | meaning
   // IDLE  | silent, waiting for start with a non-zero length
   // FETCH | one cycle: read step_idx from the RAM, voices load on exit
   // PLAY  | tick down-counter runs TICK_DIV cycles, then next step / wrap / end

   state_e                      state_q, state_d;
   logic [LEN_W-1:0]            len_q, len_d;
   logic [ADDR_W-1:0]           step_q, step_d;
   logic [TICK_W-1:0]           tick_q, tick_d;
   logic                        done_q, done_d;
   logic                        playing_q, playing_d;
   logic [AMP_W-1:0]            sample_q, sample_d;
   logic                        last_step;
   logic                        voice_load;
   logic [AMP_W-1:0]            mix;
   logic [NUM_VOICES*NOTE_W-1:0] rd_notes;
   logic [AMP_W-1:0]            contrib [NUM_VOICES];
   logic [NUM_VOICES*NOTE_W-1:0] seq_ram [SEQ_DEPTH];

   // Sequence RAM write port; contents survive reset.
   always_ff @(posedge CLOCK_50) begin
      if (note_wr_en) begin
         seq_ram[note_wr_addr] <= note_wr_data;
      end
   end

   // Read data is captured by the voices' note registers at the end of FETCH,
   // so a same-cycle write to that address is seen as old data.
   assign rd_notes   = seq_ram[step_q];
   assign last_step  = (LEN_W'(step_q) == len_q - 1'b1);
   assign voice_load = (state_q == FETCH) && (state_d == PLAY);

   // Sequencer next-state; stop has priority over start.
   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      step_d  = step_q;
      tick_d  = tick_q;
      done_d  = 1'b0;
      if (stop) begin
         state_d = IDLE;
      end else if (start && seq_len != '0) begin
         state_d = FETCH;
         len_d   = seq_len;
         step_d  = '0;
      end else begin
         case (state_q)
            FETCH: begin
               state_d = PLAY;
               tick_d  = TICK_W'(TICK_DIV - 1);
            end
            PLAY: begin
               if (tick_q == '0) begin
                  if (!last_step) begin
                     step_d  = step_q + 1'b1;
                     state_d = FETCH;
                  end else if (loop_en) begin
                     step_d  = '0;
                     state_d = FETCH;
                  end else begin
                     state_d = IDLE;
                     done_d  = 1'b1;
                  end
               end else begin
                  tick_d = tick_q - 1'b1;
               end
            end
            default: ;
         endcase
      end
      if (state_d == IDLE) begin
         tick_d = '0;
      end
      playing_d = (state_d != IDLE);
   end

   // Mixer: sum while playing, hold across FETCH, force 0 in IDLE.
   always_comb begin
      mix = '0;
      for (int v = 0; v < NUM_VOICES; v++) begin
         mix = mix + contrib[v];
      end
      if (state_d == IDLE) begin
         sample_d = '0;
      end else if (state_q == PLAY) begin
         sample_d = mix;
      end else begin
         sample_d = sample_q;
      end
   end

   // Sequencer and output registers.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state_q   <= IDLE;
         len_q     <= '0;
         step_q    <= '0;
         tick_q    <= '0;
         done_q    <= 1'b0;
         playing_q <= 1'b0;
         sample_q  <= '0;
      end else begin
         state_q   <= state_d;
         len_q     <= len_d;
         step_q    <= step_d;
         tick_q    <= tick_d;
         done_q    <= done_d;
         playing_q <= playing_d;
         sample_q  <= sample_d;
      end
   end

   for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
      square_voice #(
         .NOTE_W    (NOTE_W),
         .AMP_W     (AMP_W),
         .VOICE_AMP (VOICE_AMP)
      ) u_voice (
         .clk     (CLOCK_50),
         .reset   (reset),
         .load    (voice_load),
         .note    (rd_notes[v*NOTE_W +: NOTE_W]),
         .mute    (mute_mask[v]),
         .contrib (contrib[v])
      );
   end

   // The controller takes a sample on every allowed cycle; refused samples drop.
   assign write_audio_out = audio_out_allowed & playing_q;
   assign sample_out      = sample_q;
   assign playing         = playing_q;
   assign step_idx        = step_q;
   assign done            = done_q;

endmodule

// File: tb/tb_multi_voice_synth.sv
// Bench for multi_voice_synth with a shortened step time.
module tb_multi_voice_synth;

   localparam int NV     = 3;
   localparam int NW     = 6;
   localparam int DEPTH  = 8;
   localparam int TDIV   = 7000;
   localparam int LEN_W  = $clog2(DEPTH + 1);
   localparam int ADDR_W = $clog2(DEPTH);
   // 50e6 / (2 * 110 * 2^(62/12)) = 6327.4 for code 63
   localparam int H63    = 6327;
   localparam logic [31:0] AMP    = 32'h0800_0000;
   localparam logic [31:0] AMP_N  = 32'hF800_0000;
   localparam logic [31:0] AMP2   = 32'h1000_0000;
   localparam logic [31:0] AMP2_N = 32'hF000_0000;
   localparam logic [31:0] AMP3   = 32'h1800_0000;
   localparam logic [31:0] AMP3_N = 32'hE800_0000;

   logic                clk = 1'b0;
   logic                reset, start, stop, loop_en;
   logic [LEN_W-1:0]    seq_len;
   logic [NV-1:0]       mute_mask;
   logic                note_wr_en;
   logic [ADDR_W-1:0]   note_wr_addr;
   logic [NV*NW-1:0]    note_wr_data;
   logic                audio_out_allowed;
   logic [31:0]         sample_out;
   logic                write_audio_out, playing, done;
   logic [ADDR_W-1:0]   step_idx;

   always #5 clk = ~clk;

   multi_voice_synth #(
      .NUM_VOICES(NV), .NOTE_W(NW), .SEQ_DEPTH(DEPTH), .TICK_DIV(TDIV),
      .AMP_W(32), .VOICE_AMP(AMP)
   ) dut (
      .CLOCK_50(clk), .reset(reset), .start(start), .stop(stop),
      .loop_en(loop_en), .seq_len(seq_len), .mute_mask(mute_mask),
      .note_wr_en(note_wr_en), .note_wr_addr(note_wr_addr),
      .note_wr_data(note_wr_data), .audio_out_allowed(audio_out_allowed),
      .sample_out(sample_out), .write_audio_out(write_audio_out),
      .playing(playing), .step_idx(step_idx), .done(done)
   );

   typedef struct {
      logic [31:0]       sample;
      logic              wr;
      logic              play;
      logic              dn;
      logic [ADDR_W-1:0] idx;
   } obs_t;

   typedef struct {
      int          adv;
      logic [2:0]  mute;
      logic        allow;
      logic [31:0] s;
      logic        w;
   } vec_t;

   obs_t exp_q[$];
   int   n_vec = 0;
   int   n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic sb_push(input logic [31:0] s, input logic w, input logic p,
                          input logic d, input logic [ADDR_W-1:0] i);
      obs_t o;
      o.sample = s; o.wr = w; o.play = p; o.dn = d; o.idx = i;
      exp_q.push_back(o);
   endtask

   task automatic sb_pop(inout int bad);
      obs_t o;
      if (exp_q.size() == 0) begin
         bad++;
         return;
      end
      o = exp_q.pop_front();
      if (sample_out !== o.sample || write_audio_out !== o.wr || playing !== o.play ||
          done !== o.dn || step_idx !== o.idx)
         bad++;
   endtask

   task automatic wr_note(input int addr, input int n2, input int n1, input int n0);
      note_wr_en   = 1'b1;
      note_wr_addr = ADDR_W'(addr);
      note_wr_data = {NW'(n2), NW'(n1), NW'(n0)};
      step();
      note_wr_en   = 1'b0;
   endtask

   task automatic pulse_start(input int len);
      seq_len = LEN_W'(len);
      start   = 1'b1;
      step();
      start   = 1'b0;
   endtask

   task automatic pulse_stop();
      stop = 1'b1;
      step();
      stop = 1'b0;
   endtask

   initial begin
      #1_500_000;
      $display("FAIL watchdog: got timeout, want $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t        vt[11];
      obs_t        o;
      int          bad;
      int          k;
      int          cnt;
      logic [31:0] es;

      vt[0]  = '{0,    3'b010, 1'b1, AMP2,   1'b1};
      vt[1]  = '{0,    3'b000, 1'b1, AMP3,   1'b1};
      vt[2]  = '{0,    3'b000, 1'b0, AMP3,   1'b0};
      vt[3]  = '{0,    3'b000, 1'b1, AMP3,   1'b1};
      vt[4]  = '{0,    3'b111, 1'b1, 32'h0,  1'b1};
      vt[5]  = '{0,    3'b101, 1'b0, AMP,    1'b0};
      vt[6]  = '{0,    3'b001, 1'b1, AMP2,   1'b1};
      vt[7]  = '{6318, 3'b000, 1'b1, AMP3,   1'b1};
      vt[8]  = '{0,    3'b000, 1'b1, AMP3_N, 1'b1};
      vt[9]  = '{0,    3'b100, 1'b0, AMP2_N, 1'b0};
      vt[10] = '{0,    3'b011, 1'b1, AMP_N,  1'b1};

      reset = 1'b1; start = 1'b0; stop = 1'b0; loop_en = 1'b0; seq_len = '0;
      mute_mask = '0; note_wr_en = 1'b0; note_wr_addr = '0; note_wr_data = '0;
      audio_out_allowed = 1'b1;
      repeat (3) step();
      chk("rst_sample",  sample_out, 32'h0);
      chk("rst_write",   32'(write_audio_out), 32'd0);
      chk("rst_playing", 32'(playing), 32'd0);
      chk("rst_idx",     32'(step_idx), 32'd0);
      chk("rst_done",    32'(done), 32'd0);
      reset = 1'b0;
      step();

      // one-shot single step, voice0 on code 63
      wr_note(0, 0, 0, 63);
      loop_en = 1'b0;
      pulse_start(1);
      chk("t1_playing_rise", 32'(playing), 32'd1);
      bad = 0;
      for (int i = 1; i <= TDIV + 3; i++) begin
         es = (i < 2 || i > TDIV) ? 32'h0 : (i <= H63 + 1) ? AMP : AMP_N;
         sb_push(es, i <= TDIV, i <= TDIV, i == TDIV + 1, '0);
         step();
         sb_pop(bad);
         if (i == H63 + 1) chk("t1_last_pos", sample_out, AMP);
         if (i == H63 + 2) chk("t1_first_neg", sample_out, AMP_N);
         if (i == TDIV + 1) begin
            chk("t1_done", 32'(done), 32'd1);
            chk("t1_idle_sample", sample_out, 32'h0);
            chk("t1_idle_playing", 32'(playing), 32'd0);
         end
      end
      chk("t1_window", 32'(bad), 32'd0);

      // three rest steps, looping
      wr_note(0, 0, 0, 0);
      wr_note(1, 0, 0, 0);
      wr_note(2, 0, 0, 0);
      loop_en = 1'b1;
      pulse_start(3);
      bad = 0;
      for (int i = 1; i <= 4 * (TDIV + 1) + 2; i++) begin
         sb_push(32'h0, 1'b1, 1'b1, 1'b0, ADDR_W'((i / (TDIV + 1)) % 3));
         step();
         sb_pop(bad);
         if (i == TDIV)             chk("t2_idx_before", 32'(step_idx), 32'd0);
         if (i == TDIV + 1)         chk("t2_idx_step1",  32'(step_idx), 32'd1);
         if (i == 3 * (TDIV + 1))   chk("t2_idx_wrap",   32'(step_idx), 32'd0);
         if (i == 4 * (TDIV + 1))   chk("t2_idx_again",  32'(step_idx), 32'd1);
      end
      chk("t2_window", 32'(bad), 32'd0);
      pulse_stop();
      chk("t2_stop_playing", 32'(playing), 32'd0);
      chk("t2_stop_done", 32'(done), 32'd0);

      // mute / handshake vectors on all voices at code 63
      wr_note(0, 63, 63, 63);
      wr_note(1, 63, 63, 63);
      loop_en = 1'b0;
      mute_mask = '0;
      audio_out_allowed = 1'b1;
      pulse_start(2);
      step(); step();
      k = 2;
      chk("t3_all_on", sample_out, AMP3);
      for (int i = 0; i < 11; i++) begin
         repeat (vt[i].adv) begin
            step();
            k++;
         end
         mute_mask = vt[i].mute;
         audio_out_allowed = vt[i].allow;
         sb_push(vt[i].s, vt[i].w, 1'b1, 1'b0, '0);
         step();
         k++;
         o = exp_q.pop_front();
         chk($sformatf("t3_v%0d_sample", i), sample_out, o.sample);
         chk($sformatf("t3_v%0d_write", i), 32'(write_audio_out), 32'(o.wr));
      end
      mute_mask = '0;
      audio_out_allowed = 1'b1;
      while (k < TDIV) begin
         step();
         k++;
      end
      chk("t4_idx_hold", 32'(step_idx), 32'd0);
      step();
      chk("t4_idx_next", 32'(step_idx), 32'd1);
      chk("t4_playing", 32'(playing), 32'd1);

      // stop and start together mid-PLAY
      repeat (4) step();
      seq_len = LEN_W'(2);
      start = 1'b1;
      stop  = 1'b1;
      step();
      start = 1'b0;
      stop  = 1'b0;
      chk("t5_playing", 32'(playing), 32'd0);
      chk("t5_sample",  sample_out, 32'h0);
      chk("t5_write",   32'(write_audio_out), 32'd0);
      cnt = 0;
      for (int i = 0; i < 5; i++) begin
         if (done === 1'b1 || playing === 1'b1) cnt++;
         step();
      end
      chk("t5_stays_idle", 32'(cnt), 32'd0);
      pulse_start(0);
      chk("t5_len0_ignored", 32'(playing), 32'd0);
      step();
      chk("t5_len0_still_idle", 32'(playing), 32'd0);

      // reset during step 2, then replay from the preserved RAM
      wr_note(0, 0, 0, 63);
      wr_note(1, 0, 0, 0);
      wr_note(2, 0, 63, 0);
      pulse_start(3);
      cnt = 0;
      for (int i = 0; i < 3 * (TDIV + 1); i++) begin
         if (step_idx == ADDR_W'(2)) break;
         step();
         cnt++;
      end
      chk("t6_reach_step2_cycles", 32'(cnt), 32'(2 * (TDIV + 1)));
      repeat (10) step();
      chk("t6_step2_sample", sample_out, AMP);
      reset = 1'b1;
      step();
      chk("t6_rst_sample",  sample_out, 32'h0);
      chk("t6_rst_write",   32'(write_audio_out), 32'd0);
      chk("t6_rst_playing", 32'(playing), 32'd0);
      chk("t6_rst_idx",     32'(step_idx), 32'd0);
      chk("t6_rst_done",    32'(done), 32'd0);
      reset = 1'b0;
      step();
      loop_en = 1'b0;
      pulse_start(1);
      step(); step();
      chk("t6_replay_sample", sample_out, AMP);
      chk("t6_replay_idx", 32'(step_idx), 32'd0);
      pulse_stop();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/multi_voice_synth.md
Name: multi_voice_synth

Overview:
- Parametrised successor to the single-melody timer/note-counter/oscillator/adder audio chain in the DE2 top level.
- Plays a loadable step sequence on NUM_VOICES square-wave voices and supports loop and one-shot modes, per-voice mute and rests.
- Sums the voices into one signed sample and feeds Audio_Controller through the audio_out_allowed / write_audio_out handshake.
- Sits between system/game logic (start, stop, sequence load) and Audio_Controller.

Parameters:
- NUM_VOICES, 3, number of simultaneous square-wave voices.
- NOTE_W, 6, note code width per voice; code 0 = rest.
- SEQ_DEPTH, 64, number of sequence steps in the internal RAM.
- TICK_DIV, 12500000, CLOCK_50 cycles per step (250 ms).
- AMP_W, 32, sample width, matching the Audio_Controller channel width.
- VOICE_AMP, 32'h0800_0000, per-voice magnitude; NUM_VOICES*VOICE_AMP must be below 2^(AMP_W-1).

Ports:
- CLOCK_50  in  1  system clock.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle pulse; begin at step 0.
- stop  in  1  one-cycle pulse; abort playback.
- loop_en  in  1  1 = wrap to step 0 after the last step; 0 = one-shot.
- seq_len  in  $clog2(SEQ_DEPTH+1)  active steps, 0..SEQ_DEPTH; sampled on start.
- mute_mask  in  NUM_VOICES  bit v=1 silences voice v.
- note_wr_en  in  1  sequence RAM write strobe.
- note_wr_addr  in  $clog2(SEQ_DEPTH)  write address.
- note_wr_data  in  NUM_VOICES*NOTE_W  voice v occupies bits [v*NOTE_W +: NOTE_W].
- audio_out_allowed  in  1  from Audio_Controller; FIFO has room.
- sample_out  out  AMP_W  signed summed sample.
- write_audio_out  out  1  to Audio_Controller.
- playing  out  1  high in FETCH or PLAY.
- step_idx  out  $clog2(SEQ_DEPTH)  current step.
- done  out  1  one-cycle pulse at the end of one-shot playback.

Behaviour:
- Reset: state IDLE, sample_out=0, write_audio_out=0, playing=0, step_idx=0, done=0, tick counter=0, all voice counters=0 with phase +. RAM contents are not cleared.
- FSM states:
  - IDLE: start with seq_len!=0 latches seq_len, sets step_idx=0, goes to FETCH. start with seq_len==0 is ignored.
  - FETCH: one cycle, synchronous RAM read of step_idx, then go to PLAY. The notes load into the voices on entry to PLAY, and the tick counter clears.
  - PLAY: tick counter counts 0..TICK_DIV-1. At terminal count:
    - step_idx < len-1: step_idx+1, go to FETCH.
    - last step with loop_en=1: step_idx=0, go to FETCH.
    - last step with loop_en=0: go to IDLE and pulse done for 1 cycle.
  - Steps last TICK_DIV+1 cycles, FETCH included.
- Controls during playback:
  - stop in FETCH or PLAY: go to IDLE next cycle, no done pulse.
  - start in FETCH or PLAY: restart at step 0 via FETCH with the newly sampled seq_len.
  - stop and start in the same cycle: stop wins.
- Voice v (square_voice):
  - Half-period H = HALF_PERIOD(note) from the package.
  - Counter runs 0..H-1; phase toggles at terminal count.
  - A note load resets the counter to 0 and phase to +, even when the note is unchanged.
  - Note 0, codes beyond the table, and muted voices contribute 0 and keep counting. A mute change takes effect on the next sample.
- Mixer: registered sum of per-voice contributions (+VOICE_AMP or -VOICE_AMP, sign-extended to AMP_W). Latency is 1 cycle from phase to sample_out. In IDLE sample_out=0.
- Handshake:
  - write_audio_out = audio_out_allowed & playing, combinational.
  - Audio_Controller takes sample_out on each cycle it is asserted. No buffering; a refused cycle simply drops that sample.
  - The sequencer never stalls on audio_out_allowed.
- RAM:
  - Writes are accepted in any state.
  - Read and write to the same address in the same cycle return the old data.
  - A write to the current step affects playback only from the next FETCH of that address.
- Mid-operation reset behaves exactly like power-on reset, as listed above.

Decomposition:
- synth_pkg:
  - constant function HALF_PERIOD(note) returning 50 MHz/(2*f) for an equal-tempered table. Code 1 = A2 110 Hz, so code 25 = A4 440 Hz with half period 56818.
  - NOTE_REST = 0.
  - state enum {IDLE, FETCH, PLAY}.
- Sub-module square_voice (note, load, mute -> contribution), instantiated per voice by a generate loop. The RAM is inferred inside multi_voice_synth.

Test Plan:
- Load step0 = {25,0,0}, seq_len=1, loop_en=0, TICK_DIV=200000, audio_out_allowed=1, start:
  - playing rises the next cycle.
  - voice0 toggles every 56818 cycles.
  - sample_out alternates +/-32'h0800_0000.
  - done pulses once at cycle 200002, then sample_out=0 and playing=0.
- 3 steps, loop_en=1, TICK_DIV=10, all rests: step_idx sequence 0,1,2,0,1 at 11-cycle intervals, sample_out=0 throughout, done never asserts.
- All three voices on note 25, mute_mask=3'b010: sample_out = +/-32'h1000_0000. Clearing the mask gives +/-32'h1800_0000 on the next cycle.
- Toggle audio_out_allowed 1,0,1 while playing: write_audio_out follows it each cycle, and step timing is unchanged.
- Start with seq_len=0: stays IDLE. Stop and start in the same cycle mid-PLAY: IDLE, no done pulse.
- Reset asserted mid-PLAY at step 2: next cycle all outputs equal their reset values, and RAM still holds the loaded notes, checked by a replay.
